armleocpu_axi_read_responder: RTL and testbench

AXI4 read-channel responder (subordinate) backed by a word-addressed synchronous RAM. It serves PTW/fetch-style reads and INCR/FIXED bursts. It drives RRESP for decode and protocol errors, so the PTW access-fault path can be exercised. A backdoor write port loads page tables and images. It sits on the memory side of the PTW/cache AR/R channels, in the SoC and in benches.

---
 rtl/armleocpu_axi_read_responder_pkg.sv | 42 ++++
 rtl/armleocpu_mem_1r1w.sv | 35 +++
 rtl/armleocpu_axi_read_responder.sv | 143 ++++++++++++++
 tb/tb_armleocpu_axi_read_responder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/armleocpu_axi_read_responder_pkg.sv
// rtl/armleocpu_axi_read_responder_pkg.sv - shared AXI codes, FSM encoding and beat response rule
//
// Purpose: constants and helpers shared by the read responder and its bench.
//   AXI response codes, AXI burst codes, responder state encoding, and the
//   per-beat response priority function.
package armleocpu_axi_read_responder_pkg;

  localparam logic [1:0] ARMLEOCPU_AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] ARMLEOCPU_AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] ARMLEOCPU_AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] ARMLEOCPU_AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] ARMLEOCPU_AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] ARMLEOCPU_AXI_BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_READ = 2'd1,
    STATE_RESP = 2'd2
  } state_t;

  // Response for one beat. Protocol violations outrank decode errors so a
  // malformed request never reports DECERR.
  function automatic logic [1:0] beat_resp(input logic [1:0] burst,
                                           input logic [2:0] size,
                                           input logic [1:0] addr_lo,
                                           input logic       in_range);
    logic [1:0] resp;
    if (burst != ARMLEOCPU_AXI_BURST_FIXED && burst != ARMLEOCPU_AXI_BURST_INCR)
      resp = ARMLEOCPU_AXI_RESP_SLVERR;
    else if (size != 3'd2)
      resp = ARMLEOCPU_AXI_RESP_SLVERR;
    else if (addr_lo != 2'b00)
      resp = ARMLEOCPU_AXI_RESP_SLVERR;
    else if (!in_range)
      resp = ARMLEOCPU_AXI_RESP_DECERR;
    else
      resp = ARMLEOCPU_AXI_RESP_OKAY;
    return resp;
  endfunction

endpackage

// File: rtl/armleocpu_mem_1r1w.sv
// rtl/armleocpu_mem_1r1w.sv - synchronous read-first RAM, one read and one write port
//
// Purpose: WIDTH x DEPTH storage with registered read data.
// Ports:
//   clk      clock
//   rd_en    read enable; rd_data only updates when set, so it holds otherwise
//   rd_addr  read word index
//   rd_data  registered read data
//   wr_en    write enable
//   wr_addr  write word index
//   wr_data  write data
module armleocpu_mem_1r1w #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read and write in the same edge: the read samples the pre-write value.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
    if (rd_en)
      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/armleocpu_axi_read_responder.sv
// rtl/armleocpu_axi_read_responder.sv - AXI4 read subordinate backed by a word RAM
//
// Purpose: serves AR/R transactions (FIXED/INCR bursts) from a RAM, reporting
//   SLVERR for protocol errors and DECERR for out-of-range beats.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   axi_ar*                      read address channel (valid/ready/addr/len/size/burst/id)
//   axi_r*                       read data channel (valid/ready/data/resp/last/id)
//   init_we/init_addr/init_data  backdoor RAM write, independent of the FSM
module armleocpu_axi_read_responder
  import armleocpu_axi_read_responder_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 34,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    DEPTH_WORDS = 1024,
  parameter int                    ID_WIDTH    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           axi_arvalid,
  output logic                           axi_arready,
  input  logic [ADDR_WIDTH-1:0]          axi_araddr,
  input  logic [7:0]                     axi_arlen,
  input  logic [2:0]                     axi_arsize,
  input  logic [1:0]                     axi_arburst,
  input  logic [ID_WIDTH-1:0]            axi_arid,
  output logic                           axi_rvalid,
  input  logic                           axi_rready,
  output logic [31:0]                    axi_rdata,
  output logic [1:0]                     axi_rresp,
  output logic                           axi_rlast,
  output logic [ID_WIDTH-1:0]            axi_rid,
  input  logic                           init_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] init_addr,
  input  logic [31:0]                    init_data
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  // One extra bit so BASE_ADDR + 4*DEPTH_WORDS cannot wrap at the top of the map.
  localparam logic [ADDR_WIDTH:0] RANGE_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] RANGE_HI = RANGE_LO + ((ADDR_WIDTH+1)'(DEPTH_WORDS) << 2);

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            beats_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [ID_WIDTH-1:0]   id_q;

  logic [1:0]            rresp_q;
  logic                  rlast_q;
  logic [ID_WIDTH-1:0]   rid_q;

  logic                  in_range;
  logic [1:0]            cur_resp;
  logic [IDX_W-1:0]      word_idx;
  logic                  ram_rd_en;
  logic [31:0]           ram_q;

  assign in_range  = ({1'b0, addr_q} >= RANGE_LO) && ({1'b0, addr_q} < RANGE_HI);
  assign cur_resp  = beat_resp(burst_q, size_q, addr_q[1:0], in_range);
  assign word_idx  = IDX_W'((addr_q - BASE_ADDR) >> 2);
  // Error beats never touch the RAM; their data is forced to zero below.
  assign ram_rd_en = (state == STATE_READ) && (cur_resp == ARMLEOCPU_AXI_RESP_OKAY);

  armleocpu_mem_1r1w #(
    .WIDTH (32),
    .DEPTH (DEPTH_WORDS)
  ) u_mem (
    .clk     (clk),
    .rd_en   (ram_rd_en),
    .rd_addr (word_idx),
    .rd_data (ram_q),
    .wr_en   (init_we),
    .wr_addr (init_addr),
    .wr_data (init_data)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= STATE_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      STATE_IDLE: if (axi_arvalid) state_nxt = STATE_READ;
      STATE_READ: state_nxt = STATE_RESP;
      STATE_RESP: begin
        if (axi_rready)
          state_nxt = (beats_q != 8'd0) ? STATE_READ : STATE_IDLE;
      end
      default:    state_nxt = STATE_IDLE;
    endcase
  end

  // The RAM output register is the beat data register: it only reloads in
  // READ, so rdata stays stable through a stalled RESP.
  always_comb begin
    axi_arready = (state == STATE_IDLE) && !rst;
    axi_rvalid  = (state == STATE_RESP);
    axi_rdata   = (axi_rvalid && rresp_q == ARMLEOCPU_AXI_RESP_OKAY) ? ram_q : 32'd0;
    axi_rresp   = axi_rvalid ? rresp_q : 2'b00;
    axi_rlast   = axi_rvalid && rlast_q;
    axi_rid     = axi_rvalid ? rid_q : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      beats_q <= 8'd0;
      size_q  <= 3'd0;
      burst_q <= 2'b00;
      id_q    <= '0;
      rresp_q <= 2'b00;
      rlast_q <= 1'b0;
      rid_q   <= '0;
    end else begin
      if (state == STATE_IDLE && axi_arvalid) begin
        addr_q  <= axi_araddr;
        beats_q <= axi_arlen;
        size_q  <= axi_arsize;
        burst_q <= axi_arburst;
        id_q    <= axi_arid;
      end
      if (state == STATE_READ) begin
        rresp_q <= cur_resp;
        rlast_q <= (beats_q == 8'd0);
        rid_q   <= id_q;
      end
      if (state == STATE_RESP && axi_rready && beats_q != 8'd0) begin
        beats_q <= beats_q - 8'd1;
        if (burst_q == ARMLEOCPU_AXI_BURST_INCR)
          addr_q <= addr_q + ADDR_WIDTH'(4);
      end
    end
  end

endmodule

// File: tb/tb_armleocpu_axi_read_responder.sv
// tb/tb_armleocpu_axi_read_responder.sv - self-checking bench for the AXI read responder
module tb_armleocpu_axi_read_responder;
  import armleocpu_axi_read_responder_pkg::*;

  localparam int AW = 34;
  localparam int DEPTH = 1024;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          axi_arvalid = 1'b0;
  logic          axi_arready;
  logic [AW-1:0] axi_araddr = '0;
  logic [7:0]    axi_arlen = 8'd0;
  logic [2:0]    axi_arsize = 3'd0;
  logic [1:0]    axi_arburst = 2'b00;
  logic [IW-1:0] axi_arid = '0;
  logic          axi_rvalid;
  logic          axi_rready = 1'b0;
  logic [31:0]   axi_rdata;
  logic [1:0]    axi_rresp;
  logic          axi_rlast;
  logic [IW-1:0] axi_rid;
  logic          init_we = 1'b0;
  logic [9:0]    init_addr = '0;
  logic [31:0]   init_data = '0;

  armleocpu_axi_read_responder #(
    .ADDR_WIDTH(AW), .BASE_ADDR('0), .DEPTH_WORDS(DEPTH), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arid(axi_arid),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rid(axi_rid),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0]   data;
    logic [1:0]    resp;
    logic          last;
    logic [IW-1:0] id;
  } beat_t;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int ar_cyc = 0;
  int next_valid = 0;
  bit busy = 1'b0;
  bit prev_rst = 1'b0;
  int rready_mode = 0;
  logic rready_manual = 1'b0;

  logic [31:0] mem_model [DEPTH];
  beat_t exp_q [$];
  logic [31:0] log_data [$];
  logic [1:0]  log_resp [$];
  logic        log_last [$];
  logic [IW-1:0] log_id [$];
  int          log_cyc [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expand a request into its beats straight from the AXI rules.
  task automatic model_ar(input logic [AW-1:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [IW-1:0] id);
    longint unsigned a;
    beat_t b;
    for (int i = 0; i <= len; i++) begin
      a = (burst == 2'b01) ? ((longint'(addr) + 4 * i) & 64'h3_FFFF_FFFF) : longint'(addr);
      if (burst[1] || size != 3'd2 || a[1:0] != 2'b00) b.resp = 2'b10;
      else if (a >= 4 * DEPTH) b.resp = 2'b11;
      else b.resp = 2'b00;
      b.data = (b.resp == 2'b00) ? mem_model[(a >> 2) % DEPTH] : 32'd0;
      b.last = (i == len);
      b.id = id;
      exp_q.push_back(b);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #2;
    case (rready_mode)
      0: axi_rready = 1'b1;
      1: axi_rready = ~axi_rready;
      default: axi_rready = rready_manual;
    endcase
  end

  // Compare process: every cycle, DUT outputs against the transaction model.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("arready_in_rst", axi_arready, 1'b0);
      if (prev_rst) begin
        chk("rvalid_rst", axi_rvalid, 1'b0);
        chk("rdata_rst", axi_rdata, 32'd0);
        chk("rresp_rst", axi_rresp, 2'd0);
        chk("rlast_rst", axi_rlast, 1'b0);
        chk("rid_rst", axi_rid, 0);
      end
      exp_q.delete();
      busy = 1'b0;
      prev_rst = 1'b1;
    end else begin
      prev_rst = 1'b0;
      chk("rvalid", axi_rvalid, (exp_q.size() > 0) && (cyc >= next_valid));
      chk("arready", axi_arready, !busy);
      if (axi_rvalid && exp_q.size() > 0) begin
        chk("rdata", axi_rdata, exp_q[0].data);
        chk("rresp", axi_rresp, exp_q[0].resp);
        chk("rlast", axi_rlast, exp_q[0].last);
        chk("rid", axi_rid, exp_q[0].id);
        if (axi_rready) begin
          log_data.push_back(axi_rdata);
          log_resp.push_back(axi_rresp);
          log_last.push_back(axi_rlast);
          log_id.push_back(axi_rid);
          log_cyc.push_back(cyc);
          if (exp_q[0].last) busy = 1'b0;
          void'(exp_q.pop_front());
          next_valid = cyc + 2;
        end
      end
      if (axi_arvalid && axi_arready && !busy) begin
        model_ar(axi_araddr, int'(axi_arlen), axi_arsize, axi_arburst, axi_arid);
        busy = 1'b1;
        next_valid = cyc + 2;
      end
    end
  end

  task automatic clear_log();
    log_data.delete(); log_resp.delete(); log_last.delete(); log_id.delete(); log_cyc.delete();
  endtask

  task automatic backdoor(input int idx, input logic [31:0] d);
    init_we = 1'b1; init_addr = 10'(idx); init_data = d;
    mem_model[idx] = d;
    @(posedge clk); #1;
    init_we = 1'b0;
  endtask

  task automatic do_ar(input logic [AW-1:0] addr, input int len, input logic [2:0] size,
                       input logic [1:0] burst, input logic [IW-1:0] id, input bit collide);
    bit ok = 1'b0;
    axi_arvalid = 1'b1; axi_araddr = addr; axi_arlen = 8'(len);
    axi_arsize = size; axi_arburst = burst; axi_arid = id;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = axi_arready;
      if (ok) ar_cyc = cyc;
      @(posedge clk); #1;
    end
    axi_arvalid = 1'b0;
    if (!ok) chk("ar_handshake_timeout", 0, 1);
    if (collide) begin
      init_we = 1'b1; init_addr = 10'd0; init_data = 32'hA5A5A5A5;
      mem_model[0] = 32'hA5A5A5A5;
      @(posedge clk); #1;
      init_we = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #1;
      done = !busy && exp_q.size() == 0;
    end
    if (!done) chk("burst_timeout", 0, 1);
  endtask

  task automatic run(input logic [AW-1:0] addr, input int len, input logic [2:0] size,
                     input logic [1:0] burst, input logic [IW-1:0] id);
    clear_log();
    do_ar(addr, len, size, burst, id, 1'b0);
    wait_done(200);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) backdoor(i, 32'd0);
    backdoor(5, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) backdoor(i, 32'(i + 1));
    backdoor(1022, 32'hC0DE0001);
    backdoor(1023, 32'hC0DE0002);

    rready_mode = 0;
    run(34'h14, 0, 3'd2, 2'b01, 4'd3);
    chk("single_beats", log_data.size(), 1);
    if (log_data.size() == 1) begin
      chk("single_data", log_data[0], 32'hDEADBEEF);
      chk("single_rid", log_id[0], 4'd3);
      chk("single_latency", log_cyc[0] - ar_cyc, 2);
    end

    rready_mode = 1;
    run(34'h0, 3, 3'd2, 2'b01, 4'd1);
    chk("incr_beats", log_data.size(), 4);
    if (log_data.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("incr_data", log_data[i], 32'(i + 1));
        chk("incr_last", log_last[i], i == 3);
      end

    rready_mode = 0;
    run(34'h8, 2, 3'd2, 2'b00, 4'd2);
    chk("fixed_beats", log_data.size(), 3);
    if (log_data.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("fixed_data", log_data[i], 32'd3);
      chk("fixed_burst_end", log_cyc[2] - ar_cyc, 6);
    end

    run(34'hFF8, 3, 3'd2, 2'b01, 4'd4);
    chk("range_beats", log_data.size(), 4);
    if (log_data.size() == 4) begin
      chk("range_resp0", log_resp[0], 2'b00);
      chk("range_resp1", log_resp[1], 2'b00);
      chk("range_resp2", log_resp[2], 2'b11);
      chk("range_resp3", log_resp[3], 2'b11);
      chk("range_data1", log_data[1], 32'hC0DE0002);
      chk("range_data2", log_data[2], 32'd0);
      chk("range_last3", log_last[3], 1'b1);
    end

    run(34'h2, 0, 3'd2, 2'b01, 4'd5);
    if (log_resp.size() == 1) chk("misaligned_resp", log_resp[0], 2'b10);
    else chk("misaligned_beats", log_resp.size(), 1);
    run(34'h4, 0, 3'd1, 2'b01, 4'd6);
    if (log_resp.size() == 1) chk("size_resp", log_resp[0], 2'b10);
    else chk("size_beats", log_resp.size(), 1);
    run(34'h4, 1, 3'd2, 2'b10, 4'd7);
    chk("wrap_beats", log_resp.size(), 2);
    if (log_resp.size() == 2) begin
      chk("wrap_resp0", log_resp[0], 2'b10);
      chk("wrap_resp1", log_resp[1], 2'b10);
      chk("wrap_last1", log_last[1], 1'b1);
    end

    // Reset while beat 2 of an 8-beat burst is presented and stalled.
    rready_mode = 2;
    rready_manual = 1'b0;
    clear_log();
    do_ar(34'h0, 7, 3'd2, 2'b01, 4'd8, 1'b0);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = axi_rvalid; end
      if (!seen) chk("rst_beat1_timeout", 0, 1);
      @(posedge clk); #1 rready_manual = 1'b1;
      @(posedge clk); #1 rready_manual = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk); seen = axi_rvalid && log_data.size() == 1;
      end
      if (!seen) chk("rst_beat2_timeout", 0, 1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rvalid_after_rst", axi_rvalid, 1'b0);
    end
    rready_mode = 0;
    @(posedge clk); #1;
    run(34'h14, 0, 3'd2, 2'b01, 4'd9);
    chk("post_rst_beats", log_data.size(), 1);
    if (log_data.size() == 1) begin
      chk("post_rst_data", log_data[0], 32'hDEADBEEF);
      chk("post_rst_rid", log_id[0], 4'd9);
    end

    clear_log();
    do_ar(34'h0, 0, 3'd2, 2'b01, 4'd1, 1'b1);
    wait_done(50);
    if (log_data.size() == 1) chk("collide_old", log_data[0], 32'h1);
    else chk("collide_beats", log_data.size(), 1);
    run(34'h0, 0, 3'd2, 2'b01, 4'd1);
    if (log_data.size() == 1) chk("collide_new", log_data[0], 32'hA5A5A5A5);
    else chk("collide_new_beats", log_data.size(), 1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
